// File: rtl/amber_pkg.sv
// amber_pkg: shared widths, opcodes, cause codes and types for the Amber core
package amber_pkg;
  localparam int IW = 24;
  localparam int AW = 48;
  localparam int PW = 24;
  localparam logic [7:0] OPC_NOP = 8'h00;
  localparam logic [7:0] OPC_CSETBiv = 8'h41;
  localparam logic [7:0] OPC_HLT = 8'hFF;
  localparam int CR_PERM_SB_BIT = 5;
  localparam int SR_IDX_LR = 1;
  localparam int SR_IDX_CAUSE = 2;
  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_TAG = 3'd1,
    CAUSE_PERM = 3'd2,
    CAUSE_LEN = 3'd3,
    CAUSE_BOUNDS = 3'd4,
    CAUSE_ILLEGAL = 3'd5
  } cause_e;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_e;
  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [AW-1:0] cur;
    logic [PW-1:0] perms;
    logic [PW-1:0] attr;
    logic tag;
  } cap_t;
endpackage

// File: rtl/amber_if.sv
// amber_if: capability register file access port (one CR read, one CR write)
interface amber_if;
  import amber_pkg::*;
  logic we;
  logic [1:0] idx;
  cap_t wdata;
  cap_t rdata;
  modport master (output we, idx, wdata, input rdata);
  modport slave (input we, idx, wdata, output rdata);
endinterface

// File: rtl/amber_cap_check.sv
// amber_cap_check: prioritised tag/perm/length/bounds check for CSETBiv
module amber_cap_check import amber_pkg::*; (
  input  logic          tag,
  input  logic          perm_sb,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic [AW-1:0] cur,
  input  logic [9:0]    l,
  output cause_e        cause
);
  logic [AW:0] req_top, lim_top;
  // one extra bit so neither sum can wrap past a check
  assign req_top = {1'b0, cur} + {{(AW-9){1'b0}}, l};
  assign lim_top = {1'b0, base} + {1'b0, len};
  assign cause = !tag ? CAUSE_TAG :
                 !perm_sb ? CAUSE_PERM :
                 (l == 10'd0) ? CAUSE_LEN :
                 (cur < base || req_top > lim_top) ? CAUSE_BOUNDS : CAUSE_NONE;
endmodule

// File: rtl/amber_imem.sv
// amber_imem: instruction memory, asynchronous read, not reset
module amber_imem import amber_pkg::*; #(
  parameter int IMEM_DEPTH = 256,
  parameter int AB = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AB-1:0] waddr,
  input  logic [AB-1:0] raddr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] r_mem [IMEM_DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/amber_regcr.sv
// amber_regcr: capability registers with a single whole-CR write port
module amber_regcr import amber_pkg::*; #(
  parameter int NUM_CR = 4
) (
  input logic  clk,
  input logic  rst,
  amber_if.slave cr
);
  logic [AW-1:0] r_base [NUM_CR];
  logic [AW-1:0] r_len [NUM_CR];
  logic [AW-1:0] r_cur [NUM_CR];
  logic [PW-1:0] r_perms [NUM_CR];
  logic [PW-1:0] r_attr [NUM_CR];
  logic          r_tag [NUM_CR];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CR; i++) begin
        r_base[i] <= '0;
        r_len[i] <= '0;
        r_cur[i] <= '0;
        r_perms[i] <= '0;
        r_attr[i] <= '0;
        r_tag[i] <= 1'b0;
      end
    end else if (cr.we) begin
      r_base[cr.idx] <= cr.wdata.base;
      r_len[cr.idx] <= cr.wdata.len;
      r_cur[cr.idx] <= cr.wdata.cur;
      r_perms[cr.idx] <= cr.wdata.perms;
      r_attr[cr.idx] <= cr.wdata.attr;
      r_tag[cr.idx] <= cr.wdata.tag;
    end
  end
  assign cr.rdata = {r_base[cr.idx], r_len[cr.idx], r_cur[cr.idx],
                     r_perms[cr.idx], r_attr[cr.idx], r_tag[cr.idx]};
endmodule

// File: rtl/amber_regsr.sv
// amber_regsr: special registers, written only by the trap path (LR and CAUSE)
module amber_regsr import amber_pkg::*; #(
  parameter int NUM_SR = 8
) (
  input logic          clk,
  input logic          rst,
  input logic          lr_we,
  input logic [AW-1:0] lr_d,
  input logic          cause_we,
  input logic [AW-1:0] cause_d
);
  logic [AW-1:0] r_sr [NUM_SR];
  logic unused_sr;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SR; i++) r_sr[i] <= '0;
    end else begin
      if (lr_we) r_sr[SR_IDX_LR] <= lr_d;
      if (cause_we) r_sr[SR_IDX_CAUSE] <= cause_d;
    end
  end
  assign unused_sr = ^r_sr[0];
endmodule

// File: rtl/amber_cpu.sv
// amber_cpu: two-cycle fetch/execute core with capability bounds setting and traps
module amber_cpu import amber_pkg::*; #(
  parameter int IMEM_DEPTH = 256,
  parameter logic [AW-1:0] TRAP_VECTOR = 48'd128,
  parameter int NUM_CR = 4,
  parameter int NUM_SR = 8
) (
  input logic iw_clk,
  input logic iw_rst
);
  localparam int AB = $clog2(IMEM_DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d, imem_rdata;
  logic [7:0] opcode;
  logic trap, unused_ir;
  cause_e chk_cause, trap_cause;
  amber_if cr_bus ();
  amber_imem #(.IMEM_DEPTH(IMEM_DEPTH), .AB(AB)) u_imem (
    .clk(iw_clk), .we(1'b0), .waddr('0), .raddr(pc_q[AB-1:0]), .wdata('0), .rdata(imem_rdata)
  );
  amber_regcr #(.NUM_CR(NUM_CR)) u_regcr (.clk(iw_clk), .rst(iw_rst), .cr(cr_bus.slave));
  amber_regsr #(.NUM_SR(NUM_SR)) u_regsr (
    .clk(iw_clk), .rst(iw_rst),
    .lr_we(trap), .lr_d(pc_q + 1'b1),
    .cause_we(trap), .cause_d({{(AW-3){1'b0}}, trap_cause})
  );
  amber_cap_check u_check (
    .tag(cr_bus.rdata.tag), .perm_sb(cr_bus.rdata.perms[CR_PERM_SB_BIT]),
    .base(cr_bus.rdata.base), .len(cr_bus.rdata.len), .cur(cr_bus.rdata.cur),
    .l(ir_q[9:0]), .cause(chk_cause)
  );
  assign opcode = ir_q[23:16];
  assign unused_ir = ^ir_q[15:12];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    trap = 1'b0;
    trap_cause = CAUSE_NONE;
    cr_bus.we = 1'b0;
    cr_bus.idx = ir_q[11:10];
    cr_bus.wdata = cr_bus.rdata;
    cr_bus.wdata.base = cr_bus.rdata.cur;
    cr_bus.wdata.len = {{(AW-10){1'b0}}, ir_q[9:0]};
    case (state_q)
      ST_FETCH: begin
        ir_d = imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (opcode == OPC_HLT) ? ST_HALT : ST_FETCH;
        if (opcode == OPC_NOP) pc_d = pc_q + 1'b1;
        else if (opcode == OPC_CSETBiv && chk_cause == CAUSE_NONE) begin
          cr_bus.we = 1'b1;
          pc_d = pc_q + 1'b1;
        end else if (opcode != OPC_HLT) begin
          trap = 1'b1;
          trap_cause = (opcode == OPC_CSETBiv) ? chk_cause : CAUSE_ILLEGAL;
          pc_d = TRAP_VECTOR;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= ST_FETCH;
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end
endmodule

// File: tb/tb_amber_cpu.sv
// tb_amber_cpu: directed plan cases plus random short programs against an ISA-level model
module tb_amber_cpu;
  import amber_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  amber_cpu dut (.iw_clk(clk), .iw_rst(rst));
  int checks = 0;
  int failures = 0;
  localparam longint unsigned MASK = 64'hFFFF_FFFF_FFFF;
  longint unsigned m_base[4], m_len[4], m_cur[4];
  logic [23:0] m_perms[4], m_attr[4];
  bit m_tag[4];
  longint unsigned m_lr, m_cause, m_pc;
  bit m_halt;
  logic [23:0] img[256];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_all();
    for (int i = 0; i < 256; i++) img[i] = {OPC_HLT, 16'h0};
    for (int i = 0; i < 4; i++) set_cr(i, 0, 0, 0, 24'h0, 1'b0);
  endtask
  task automatic set_cr(input int i, input longint unsigned b, input longint unsigned l,
                        input longint unsigned c, input logic [23:0] p, input bit t);
    m_base[i] = b & MASK;
    m_len[i] = l & MASK;
    m_cur[i] = c & MASK;
    m_perms[i] = p;
    m_attr[i] = 24'($urandom);
    m_tag[i] = t;
  endtask
  task automatic model_run();
    logic [23:0] ins;
    logic [7:0] op;
    int ci;
    longint unsigned l, c;
    m_pc = 0; m_lr = 0; m_cause = 0; m_halt = 0;
    for (int n = 0; n < 100 && !m_halt; n++) begin
      ins = img[m_pc % 256];
      op = ins[23:16];
      c = 0;
      if (op == OPC_HLT) m_halt = 1;
      else if (op == OPC_NOP) m_pc = (m_pc + 1) & MASK;
      else begin
        if (op == OPC_CSETBiv) begin
          ci = int'(ins[11:10]);
          l = longint'(ins[9:0]);
          if (!m_tag[ci]) c = 1;
          else if (!m_perms[ci][CR_PERM_SB_BIT]) c = 2;
          else if (l == 0) c = 3;
          else if (m_cur[ci] < m_base[ci] || m_cur[ci] + l > m_base[ci] + m_len[ci]) c = 4;
          if (c == 0) begin
            m_base[ci] = m_cur[ci];
            m_len[ci] = l;
          end
        end else c = 5;
        if (c == 0) m_pc = (m_pc + 1) & MASK;
        else begin
          m_lr = (m_pc + 1) & MASK;
          m_cause = c;
          m_pc = 128;
        end
      end
    end
  endtask
  task automatic run(input string name, input int cycles);
    for (int i = 0; i < 256; i++) dut.u_imem.r_mem[i] <= img[i];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dut.u_regcr.r_base[i] <= m_base[i][47:0];
      dut.u_regcr.r_len[i] <= m_len[i][47:0];
      dut.u_regcr.r_cur[i] <= m_cur[i][47:0];
      dut.u_regcr.r_perms[i] <= m_perms[i];
      dut.u_regcr.r_attr[i] <= m_attr[i];
      dut.u_regcr.r_tag[i] <= m_tag[i];
    end
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    model_run();
    check({name, "_pc"}, dut.pc_q, m_pc);
    check({name, "_halt"}, dut.state_q == ST_HALT, m_halt);
    check({name, "_lr"}, dut.u_regsr.r_sr[SR_IDX_LR], m_lr);
    check({name, "_cause"}, dut.u_regsr.r_sr[SR_IDX_CAUSE], m_cause);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_base%0d", name, i), dut.u_regcr.r_base[i], m_base[i]);
      check($sformatf("%s_len%0d", name, i), dut.u_regcr.r_len[i], m_len[i]);
      check($sformatf("%s_cur%0d", name, i), dut.u_regcr.r_cur[i], m_cur[i]);
      check($sformatf("%s_perms%0d", name, i), dut.u_regcr.r_perms[i], m_perms[i]);
      check($sformatf("%s_attr%0d", name, i), dut.u_regcr.r_attr[i], m_attr[i]);
      check($sformatf("%s_tag%0d", name, i), dut.u_regcr.r_tag[i], m_tag[i]);
    end
  endtask
  initial begin
    logic [23:0] ins;
    logic [7:0] op;
    int n, sel;
    longint unsigned b;
    clear_all();
    set_cr(0, 100, 50, 110, 24'h20, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 14'd0};
    run("len0", 200);
    check("len0_cause_const", dut.u_regsr.r_sr[SR_IDX_CAUSE], 3);
    check("len0_lr_const", dut.u_regsr.r_sr[SR_IDX_LR], 1);
    check("len0_pc_const", dut.pc_q, 128);
    clear_all();
    set_cr(0, 100, 50, 110, 24'h20, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 14'd20};
    run("ok", 200);
    check("ok_base_const", dut.u_regcr.r_base[0], 110);
    check("ok_len_const", dut.u_regcr.r_len[0], 20);
    check("ok_pc_const", dut.pc_q, 1);
    check("ok_lr_const", dut.u_regsr.r_sr[SR_IDX_LR], 0);
    clear_all();
    set_cr(0, 100, 50, 110, 24'h20, 1'b0);
    img[0] = {OPC_CSETBiv, 2'b00, 14'd5};
    run("tag", 200);
    check("tag_cause_const", dut.u_regsr.r_sr[SR_IDX_CAUSE], 1);
    clear_all();
    set_cr(1, 100, 50, 110, 24'h0, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 2'b00, 2'b01, 10'd5};
    run("perm", 200);
    check("perm_cause_const", dut.u_regsr.r_sr[SR_IDX_CAUSE], 2);
    clear_all();
    set_cr(0, 100, 50, 140, 24'h20, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 14'd20};
    run("bounds", 200);
    check("bounds_cause_const", dut.u_regsr.r_sr[SR_IDX_CAUSE], 4);
    clear_all();
    set_cr(2, 64'hFFFF_FFFF_FFF0, 64'hFF, 64'hFFFF_FFFF_FFF8, 24'hFFFFFF, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 2'b00, 2'b10, 10'd10};
    img[1] = {OPC_NOP, 16'h0};
    run("wrap_ok", 200);
    clear_all();
    set_cr(3, 64'hFFFF_FFFF_FFF0, 64'h8, 64'hFFFF_FFFF_FFF4, 24'hFFFFFF, 1'b1);
    img[0] = {OPC_CSETBiv, 2'b00, 2'b00, 2'b11, 10'd5};
    run("wrap_bad", 200);
    clear_all();
    img[0] = {8'h12, 16'h0};
    run("illegal", 200);
    check("illegal_cause_const", dut.u_regsr.r_sr[SR_IDX_CAUSE], 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_pc", dut.pc_q, 0);
    check("rst_state", dut.state_q, ST_FETCH);
    for (int i = 0; i < 8; i++) check($sformatf("rst_sr%0d", i), dut.u_regsr.r_sr[i], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("restart_cause", dut.u_regsr.r_sr[SR_IDX_CAUSE], 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_lr", dut.u_regsr.r_sr[SR_IDX_LR], 0);
    check("abort_cause", dut.u_regsr.r_sr[SR_IDX_CAUSE], 0);
    check("abort_pc", dut.pc_q, 0);
    for (int t = 0; t < 25; t++) begin
      clear_all();
      for (int i = 0; i < 4; i++) begin
        b = longint'($urandom_range(10, 300));
        set_cr(i, b, longint'($urandom_range(0, 100)), b + longint'($urandom_range(0, 130)) - 10,
               24'($urandom) | (($urandom_range(0, 3) != 0) ? 24'h20 : 24'h0),
               $urandom_range(0, 4) != 0);
      end
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 9);
        op = 8'($urandom_range(1, 254));
        if (op == OPC_CSETBiv) op = 8'h42;
        if (sel < 2) ins = {OPC_NOP, 16'($urandom)};
        else if (sel < 8) ins = {OPC_CSETBiv, 4'($urandom), 2'($urandom), 10'($urandom_range(0, 60))};
        else ins = {op, 16'($urandom)};
        img[k] = ins;
      end
      run($sformatf("rnd%0d", t), 200);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
